// File: rtl/pll_pkg.sv
// Shared PLL types and defaults used by the phase detector and the loop filter.
package pll_pkg;

    localparam int unsigned ERR_SIZE_DEFAULT    = 16;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        PD_IDLE,
        PD_REF_LEAD,
        PD_FB_LEAD
    } pd_state_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous clock-like input into the local domain and
// produces a one-cycle pulse on each synchronized rising edge.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic n_rst,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge i_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/phase_detector.sv
// Counter-based phase/frequency detector: signed delay, in clk_fast cycles,
// from the reference rising edge to the feedback rising edge.
module phase_detector
    import pll_pkg::*;
#(
    parameter int unsigned ERR_SIZE    = ERR_SIZE_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                       i_clk_fast,
    input  logic                       n_rst,
    input  logic                       i_clear,
    input  logic                       i_clk_ref_in,
    input  logic                       i_clk_fb_in,
    output logic signed [ERR_SIZE-1:0] o_error,
    output logic                       o_err_valid,
    output logic                       o_enable,
    output logic                       o_lost_lock
);

    localparam logic [ERR_SIZE-2:0]        CountMax = '1;
    localparam logic [ERR_SIZE-2:0]        CountOne = {{(ERR_SIZE-2){1'b0}}, 1'b1};
    localparam logic signed [ERR_SIZE-1:0] ErrMax   = {1'b0, CountMax};

    logic w_ref_rise;
    logic w_fb_rise;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ref_sync (
        .i_clk  (i_clk_fast),
        .n_rst  (n_rst),
        .i_async(i_clk_ref_in),
        .o_rise (w_ref_rise)
    );

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_fb_sync (
        .i_clk  (i_clk_fast),
        .n_rst  (n_rst),
        .i_async(i_clk_fb_in),
        .o_rise (w_fb_rise)
    );

    pd_state_t                   r_state;
    pd_state_t                   w_state_d;
    logic [ERR_SIZE-2:0]         r_count;
    logic [ERR_SIZE-2:0]         w_count_d;
    logic signed [ERR_SIZE-1:0]  r_error;
    logic                        r_err_valid;
    logic                        r_enable;
    logic                        r_lost_lock;
    logic                        w_pub;
    logic signed [ERR_SIZE-1:0]  w_pub_val;
    logic                        w_lost;
    logic signed [ERR_SIZE-1:0]  w_count_pos;

    assign w_count_pos = {1'b0, r_count};

    always_comb begin
        w_state_d = r_state;
        w_count_d = r_count;
        w_pub     = 1'b0;
        w_pub_val = '0;
        w_lost    = 1'b0;
        unique case (r_state)
            PD_IDLE: begin
                if (w_ref_rise && w_fb_rise) begin
                    w_pub = 1'b1;
                end else if (w_ref_rise) begin
                    w_state_d = PD_REF_LEAD;
                    w_count_d = CountOne;
                end else if (w_fb_rise) begin
                    w_state_d = PD_FB_LEAD;
                    w_count_d = CountOne;
                end
            end
            PD_REF_LEAD: begin
                if (w_fb_rise) begin
                    w_pub     = 1'b1;
                    w_pub_val = w_count_pos;
                    // A coincident ref edge opens the next measurement immediately.
                    if (w_ref_rise) begin
                        w_count_d = CountOne;
                    end else begin
                        w_state_d = PD_IDLE;
                        w_count_d = '0;
                    end
                end else if (w_ref_rise) begin
                    w_pub     = 1'b1;
                    w_pub_val = ErrMax;
                    w_count_d = CountOne;
                end else if (r_count == CountMax) begin
                    w_pub     = 1'b1;
                    w_pub_val = ErrMax;
                    w_lost    = 1'b1;
                    w_state_d = PD_IDLE;
                    w_count_d = '0;
                end else begin
                    w_count_d = r_count + CountOne;
                end
            end
            PD_FB_LEAD: begin
                if (w_ref_rise) begin
                    w_pub     = 1'b1;
                    w_pub_val = -w_count_pos;
                    if (w_fb_rise) begin
                        w_count_d = CountOne;
                    end else begin
                        w_state_d = PD_IDLE;
                        w_count_d = '0;
                    end
                end else if (w_fb_rise) begin
                    w_pub     = 1'b1;
                    w_pub_val = -ErrMax;
                    w_count_d = CountOne;
                end else if (r_count == CountMax) begin
                    w_pub     = 1'b1;
                    w_pub_val = -ErrMax;
                    w_lost    = 1'b1;
                    w_state_d = PD_IDLE;
                    w_count_d = '0;
                end else begin
                    w_count_d = r_count + CountOne;
                end
            end
            default: begin
                w_state_d = PD_IDLE;
                w_count_d = '0;
            end
        endcase
        if (i_clear) begin
            w_state_d = PD_IDLE;
            w_count_d = '0;
            w_pub     = 1'b0;
            w_lost    = 1'b0;
        end
    end

    always_ff @(posedge i_clk_fast or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= PD_IDLE;
            r_count     <= '0;
            r_error     <= '0;
            r_err_valid <= 1'b0;
            r_enable    <= 1'b0;
            r_lost_lock <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_count     <= w_count_d;
            r_err_valid <= w_pub;
            if (w_pub) begin
                r_error <= w_pub_val;
            end
            // Error is deliberately held across clear so the filter keeps its last input.
            if (i_clear) begin
                r_enable    <= 1'b0;
                r_lost_lock <= 1'b0;
            end else begin
                if (w_pub) begin
                    r_enable <= 1'b1;
                end
                if (w_lost) begin
                    r_lost_lock <= 1'b1;
                end
            end
        end
    end

    assign o_error     = r_error;
    assign o_err_valid = r_err_valid;
    assign o_enable    = r_enable;
    assign o_lost_lock = r_lost_lock;

endmodule
